// File: rtl/seq_mult_addsub.sv
// Sequential shift-and-add multiplier, one partial product per clock, signed or unsigned.
// A (WIDTH+1)-bit add/subtract datapath accumulates into Areg while the multiplier shifts out of Breg.
module seq_mult_addsub #(
   parameter int WIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic                 Signed_mode,
   input  logic [WIDTH-1:0]     A_in,
   input  logic [WIDTH-1:0]     B_in,
   output logic                 Busy,
   output logic                 Done,
   output logic [2*WIDTH-1:0]   Product,
   output logic                 X_out
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_areg;
   logic [WIDTH-1:0]   r_breg;
   logic [WIDTH-1:0]   r_sreg;
   logic               r_x;
   logic [CW-1:0]      r_count;
   logic               r_mode;
   logic               r_busy;
   logic               r_done;
   logic [2*WIDTH-1:0] r_product;

   logic [WIDTH:0]     w_ext_a;
   logic [WIDTH:0]     w_ext_s;
   logic               w_sub;
   logic [WIDTH:0]     w_addend;
   logic               w_cin;
   logic [WIDTH:0]     w_sum;

   assign w_ext_a  = {r_mode & r_areg[WIDTH-1], r_areg};
   assign w_ext_s  = {r_mode & r_sreg[WIDTH-1], r_sreg};
   // The multiplier's top bit carries negative weight in signed mode, so the last step subtracts.
   assign w_sub    = r_mode && (r_count == LAST);
   assign w_addend = r_breg[0] ? (w_sub ? ~w_ext_s : w_ext_s) : '0;
   assign w_cin    = r_breg[0] & w_sub;
   assign w_sum    = w_ext_a + w_addend + {{WIDTH{1'b0}}, w_cin};

   // Handshake: Start is a level sampled only in IDLE; Done rises one cycle after the last
   // iteration and, with Product, holds until the next launch, so a held Start fires once.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state   <= IDLE;
         r_areg    <= '0;
         r_breg    <= '0;
         r_sreg    <= '0;
         r_x       <= 1'b0;
         r_count   <= '0;
         r_mode    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (Start) begin
                  r_sreg  <= A_in;
                  r_breg  <= B_in;
                  r_areg  <= '0;
                  r_x     <= 1'b0;
                  r_count <= '0;
                  r_mode  <= Signed_mode;
                  r_done  <= 1'b0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_busy  <= 1'b1;
               r_x     <= r_mode & w_sum[WIDTH];
               r_areg  <= w_sum[WIDTH:1];
               r_breg  <= {w_sum[0], r_breg[WIDTH-1:1]};
               r_count <= r_count + CW'(1);
               if (r_count == LAST) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_busy    <= 1'b0;
               r_done    <= 1'b1;
               r_product <= {r_areg, r_breg};
               if (!Start) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign Busy    = r_busy;
   assign Done    = r_done;
   assign Product = r_product;
   assign X_out   = r_x;

endmodule

// File: tb/tb_seq_mult_addsub.sv
// Bench for seq_mult_addsub: 8-bit and 16-bit instances checked against a plain-arithmetic product model.
module tb_seq_mult_addsub;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic        Signed_mode;
   logic [7:0]  A_in;
   logic [7:0]  B_in;
   logic        Busy;
   logic        Done;
   logic [15:0] Product;
   logic        X_out;

   logic        s16_start;
   logic        s16_mode;
   logic [15:0] s16_a;
   logic [15:0] s16_b;
   logic        s16_busy;
   logic        s16_done;
   logic [31:0] s16_product;
   logic        s16_x;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   seq_mult_addsub #(.WIDTH(8)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Signed_mode(Signed_mode),
      .A_in(A_in), .B_in(B_in), .Busy(Busy), .Done(Done),
      .Product(Product), .X_out(X_out)
   );

   seq_mult_addsub #(.WIDTH(16)) dut16 (
      .Clk(Clk), .Reset(Reset), .Start(s16_start), .Signed_mode(s16_mode),
      .A_in(s16_a), .B_in(s16_b), .Busy(s16_busy), .Done(s16_done),
      .Product(s16_product), .X_out(s16_x)
   );

   // Clock and reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
      longint p;
      if (s) p = longint'($signed(a)) * longint'($signed(b));
      else   p = longint'(a) * longint'(b);
      return p[15:0];
   endfunction

   function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
      longint p;
      if (s) p = longint'($signed(a)) * longint'($signed(b));
      else   p = longint'(a) * longint'(b);
      return p[31:0];
   endfunction

   // Drivers
   task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit hold);
      @(negedge Clk);
      A_in = a; B_in = b; Signed_mode = s; Start = 1'b1;
      @(posedge Clk); #1;
      if (!hold) Start = 1'b0;
      A_in = 8'($urandom); B_in = 8'($urandom); Signed_mode = 1'($urandom);
   endtask

   task automatic wait_done8(output int lat, output int busy_cyc, output int overlap);
      lat = -1; busy_cyc = 0; overlap = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge Clk); #1;
         if (Busy) busy_cyc++;
         if (Busy && Done) overlap++;
         if (Done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
      checks++; if (Product !== 16'h0) begin errors++; $display("FAIL reset_product: got %h expected 0000", Product); end
      checks++; if (X_out !== 1'b0) begin errors++; $display("FAIL reset_x: got %b expected 0", X_out); end
   endtask

   task automatic test_directed;
      logic [7:0]  ta[5] = '{8'hC5, 8'h80, 8'h7F, 8'hFF, 8'hFF};
      logic [7:0]  tb[5] = '{8'h07, 8'h80, 8'h80, 8'hFF, 8'hFF};
      logic        ts[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [15:0] tp[5] = '{16'hFE63, 16'h4000, 16'hC080, 16'hFE01, 16'h0001};
      int lat, bc, ov;
      for (int i = 0; i < 5; i++) begin
         launch8(ta[i], tb[i], ts[i], 1'b0);
         wait_done8(lat, bc, ov);
         checks++; if (lat != 9) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 9", i, lat); end
         checks++; if (bc != 8) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected 8", i, bc); end
         checks++; if (Product !== tp[i]) begin errors++; $display("FAIL dir%0d_product: got %h expected %h", i, Product, tp[i]); end
         checks++; if (ov != 0) begin errors++; $display("FAIL dir%0d_busy_done_overlap: got %0d expected 0", i, ov); end
      end
   endtask

   task automatic test_random;
      int lat, bc, ov;
      logic [7:0] a, b;
      logic s;
      logic [15:0] exp_p;
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         s = 1'($urandom_range(0, 1));
         exp_q.push_back(model8(a, b, s));
         launch8(a, b, s, 1'b0);
         wait_done8(lat, bc, ov);
         exp_p = exp_q.pop_front();
         checks++; if (lat != 9) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected 9", i, lat); end
         checks++; if (Product !== exp_p) begin errors++; $display("FAIL rnd%0d_product: a=%h b=%h s=%b got %h expected %h", i, a, b, s, Product, exp_p); end
         checks++; if (X_out !== (s & exp_p[15])) begin errors++; $display("FAIL rnd%0d_x: got %b expected %b", i, X_out, s & exp_p[15]); end
         // Idle gap of random length between operations
         repeat ($urandom_range(0, 2)) @(posedge Clk);
      end
   endtask

   task automatic test_start_held;
      int busy_cyc = 0;
      int unstable = 0;
      int lat, bc, ov;
      logic [15:0] exp_p, first_p;
      bit seen = 0;
      exp_p = model8(8'h5B, 8'hA7, 1'b1);
      launch8(8'h5B, 8'hA7, 1'b1, 1'b1);
      for (int k = 1; k < 30; k++) begin
         @(posedge Clk); #1;
         if (Busy) busy_cyc++;
         if (Done) begin
            if (!seen) begin first_p = Product; seen = 1; end
            else if (Product !== first_p) unstable++;
         end
      end
      checks++; if (busy_cyc != 8) begin errors++; $display("FAIL held_busy_cycles: got %0d expected 8", busy_cyc); end
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL held_done: got %b expected 1", Done); end
      checks++; if (Product !== exp_p) begin errors++; $display("FAIL held_product: got %h expected %h", Product, exp_p); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL held_stable: got %0d changes expected 0", unstable); end
      @(negedge Clk); Start = 1'b0;
      repeat (2) @(posedge Clk);
      launch8(8'h00, 8'h5A, 1'b1, 1'b0);
      wait_done8(lat, bc, ov);
      checks++; if (lat != 9) begin errors++; $display("FAIL held_relaunch_latency: got %0d expected 9", lat); end
      checks++; if (Product !== 16'h0000) begin errors++; $display("FAIL held_relaunch_product: got %h expected 0000", Product); end
   endtask

   task automatic test_reset_mid_run;
      int lat, bc, ov;
      launch8(8'hC5, 8'h07, 1'b1, 1'b0);
      repeat (4) @(posedge Clk);
      #2;
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL midrun_busy_before_reset: got %b expected 1", Busy); end
      Reset = 1'b1;
      #1;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrun_busy: got %b expected 0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL midrun_done: got %b expected 0", Done); end
      checks++; if (Product !== 16'h0) begin errors++; $display("FAIL midrun_product: got %h expected 0000", Product); end
      checks++; if (X_out !== 1'b0) begin errors++; $display("FAIL midrun_x: got %b expected 0", X_out); end
      @(negedge Clk); Reset = 1'b0;
      @(posedge Clk);
      launch8(8'h03, 8'hFD, 1'b1, 1'b0);
      wait_done8(lat, bc, ov);
      checks++; if (lat != 9) begin errors++; $display("FAIL post_reset_latency: got %0d expected 9", lat); end
      checks++; if (Product !== 16'hFFF7) begin errors++; $display("FAIL post_reset_product: got %h expected fff7", Product); end
   endtask

   task automatic test_w16;
      logic [15:0] a[4];
      logic [15:0] b[4];
      logic        s[4];
      logic [31:0] exp_p;
      int lat;
      a[0] = 16'h8000; b[0] = 16'h0002; s[0] = 1'b1;
      for (int i = 1; i < 4; i++) begin
         a[i] = 16'($urandom); b[i] = 16'($urandom); s[i] = 1'($urandom);
      end
      for (int i = 0; i < 4; i++) begin
         exp_p = (i == 0) ? 32'hFFFF0000 : model16(a[i], b[i], s[i]);
         @(negedge Clk);
         s16_a = a[i]; s16_b = b[i]; s16_mode = s[i]; s16_start = 1'b1;
         @(posedge Clk); #1;
         s16_start = 1'b0;
         lat = -1;
         for (int k = 1; k <= 60; k++) begin
            @(posedge Clk); #1;
            if (s16_done) begin lat = k; break; end
         end
         checks++; if (lat != 17) begin errors++; $display("FAIL w16_%0d_latency: got %0d expected 17", i, lat); end
         checks++; if (s16_product !== exp_p) begin errors++; $display("FAIL w16_%0d_product: got %h expected %h", i, s16_product, exp_p); end
      end
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Signed_mode = 1'b0; A_in = '0; B_in = '0;
      s16_start = 1'b0; s16_mode = 1'b0; s16_a = '0; s16_b = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk); Reset = 1'b0;
      @(posedge Clk); #1;
      test_reset;
      test_directed;
      test_random;
      test_start_held;
      test_reset_mid_run;
      test_w16;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_mult_addsub.md
Name: seq_mult_addsub

Overview:
- Parametrised sequential shift-and-add multiplier built around a (WIDTH+1)-bit add/subtract datapath, one partial product per clock.
- Supports signed (two's complement) and unsigned operands, selected per operation.
- Sits between the switch/register front-end and the hex display path.
- Uses a Start/Done handshake so a push-button or upstream controller can launch one multiply per press.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  level request; sampled only in IDLE.
- Signed_mode  input  1  1 = signed two's-complement multiply, 0 = unsigned; captured with operands.
- A_in  input  WIDTH  multiplicand, captured on launch.
- B_in  input  WIDTH  multiplier, captured on launch.
- Busy  output  1  high while in RUN.
- Done  output  1  high in DONE state.
- Product  output  2*WIDTH  result {Areg, Breg}; valid while Done=1, holds until next launch.
- X_out  output  1  extension bit of the accumulator, for debug display.

Behaviour:
- Reset (async, any state, including mid-RUN) clears:
  - outputs Busy=0, Done=0, Product=0, X_out=0;
  - internal regs Areg=0, Breg=0, Sreg=0, X=0, count=0, mode=0;
  - state=IDLE.
- Registers:
  - Sreg (WIDTH) holds the multiplicand.
  - Areg (WIDTH) is the accumulator.
  - Breg (WIDTH) holds the multiplier, shifting right.
  - X (1) is the extension bit.
  - count is $clog2(WIDTH+1) bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If Start=1: load Sreg=A_in, Breg=B_in, Areg=0, X=0, count=0, mode=Signed_mode; go to RUN.
  - Otherwise hold all registers.
- RUN: one iteration per cycle for count = 0..WIDTH-1.
  - Extend Areg and Sreg to WIDTH+1 bits: sign-extend if mode=1, zero-extend if mode=0.
  - If Breg[0]=1:
    - sum = ext(Areg) + ext(Sreg) when count<WIDTH-1, or when mode=0;
    - sum = ext(Areg) - ext(Sreg) when count==WIDTH-1 and mode=1 (sign-weight correction);
    - subtract is invert-and-carry-in-1 on the (WIDTH+1)-bit adder.
  - If Breg[0]=0: sum = ext(Areg).
  - Same cycle shift: {X, Areg, Breg} <= {s, sum[WIDTH:0], Breg[WIDTH-1:1]} >> arrangement, i.e. new X = sum[WIDTH] if mode=1 else 0, new Areg = sum[WIDTH:1], new Breg = {sum[0], Breg[WIDTH-1:1]}.
  - count increments; after the iteration with count==WIDTH-1, go to DONE.
  - Overflow beyond WIDTH+1 bits is impossible by construction; no saturation.
- DONE:
  - Done=1 and Product={Areg, Breg}.
  - Stay while Start=1, so a held button does not re-trigger.
  - When Start=0, go to IDLE; Product and Done hold until the next launch, then Done drops in the launch cycle.
- Latency: Start sampled high in IDLE at edge N → Done=1 after edge N+WIDTH+1. Exactly WIDTH RUN cycles, independent of operand values.
- Busy=1 only in RUN; Done and Busy are never both high.
- A_in, B_in, Signed_mode changes during RUN/DONE are ignored.
- Start pulsed for one cycle is sufficient; Start held high across DONE→IDLE launches exactly one operation per low→high cycle.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, Signed_mode=1, A_in=8'hC5 (-59), B_in=8'h07 → Done rises exactly 9 cycles after launch edge, Product=16'hFE63 (-413), Busy high for 8 cycles.
- WIDTH=8, Signed_mode=1, A_in=8'h80, B_in=8'h80 → Product=16'h4000; then A_in=8'h7F, B_in=8'h80 → Product=16'hC080 (-16256).
- WIDTH=8, Signed_mode=0, A_in=8'hFF, B_in=8'hFF → Product=16'hFE01 (65025); same operands with Signed_mode=1 → 16'h0001.
- Start held high 30 cycles: exactly one operation; Done stays 1, Product is stable; Start low → IDLE; second Start with A_in=0, B_in=8'h5A → Product=0.
- Assert Reset at RUN cycle 4 of a multiply → all outputs 0 immediately (async), state IDLE; next Start with 8'h03 × 8'hFD (signed) → Product=16'hFFF7.
- WIDTH=16 instance, signed, 16'h8000 × 16'h0002 → Product=32'hFFFF0000, Done after 17 cycles.
